// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared CPU datapath constants, ALU opcodes and helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int WIDTH = 8;
    localparam int NREGS = 8;
    localparam int AW    = $clog2(NREGS);
    localparam int OPW   = 3;

    typedef enum logic [OPW-1:0] {
        OP_FWD = 3'b000,
        OP_ADD = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_ROR = 3'b100,
        OP_MUL = 3'b101,
        OP_SRA = 3'b110,
        OP_SL  = 3'b111
    } alu_op_e;

    // Two's complement negation; wraps so 0x00 and 0x80 map to themselves.
    function automatic logic [WIDTH-1:0] twos_neg(input logic [WIDTH-1:0] v);
        return ~v + WIDTH'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
// Module      : reg_file
// Description : NREGS x WIDTH register array, two write-first bypassed reads.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file
    import cpu_pkg::*;
(
    input  logic             CLK,
    input  logic             RESET,
    input  logic             WRITE,
    input  logic [AW-1:0]    INADDRESS,
    input  logic [WIDTH-1:0] IN,
    input  logic [AW-1:0]    RADDR1,
    input  logic [AW-1:0]    RADDR2,
    output logic [WIDTH-1:0] RDATA1,
    output logic [WIDTH-1:0] RDATA2
);

    logic [WIDTH-1:0] r_regs_q [NREGS];
    logic [WIDTH-1:0] w_regs_d [NREGS];

    always_comb begin
        w_regs_d = r_regs_q;
        if (WRITE) begin
            w_regs_d[INADDRESS] = IN;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs_q[i] <= '0;
            end
        end else begin
            r_regs_q <= w_regs_d;
        end
    end

    // A write landing this edge is forwarded to same-cycle readers.
    assign RDATA1 = (WRITE && (INADDRESS == RADDR1)) ? IN : r_regs_q[RADDR1];
    assign RDATA2 = (WRITE && (INADDRESS == RADDR2)) ? IN : r_regs_q[RADDR2];

endmodule
`default_nettype wire

// File: rtl/operand_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : operand_fetch_stage
// Description : Register read, operand-2 select/negate and ALU input register.
// Revision    : 1.0 - initial release
// ============================================================================
module operand_fetch_stage
    import cpu_pkg::*;
(
    input  logic             CLK,
    input  logic             RESET,
    input  logic             IN_VALID,
    input  logic [AW-1:0]    OUT1ADDRESS,
    input  logic [AW-1:0]    OUT2ADDRESS,
    input  logic [WIDTH-1:0] IMMEDIATE,
    input  logic             IMM_SEL,
    input  logic             NEG_SEL,
    input  logic [OPW-1:0]   ALUOP_IN,
    input  logic             STALL,
    input  logic             WRITE,
    input  logic [AW-1:0]    INADDRESS,
    input  logic [WIDTH-1:0] IN,
    output logic [WIDTH-1:0] DATA1,
    output logic [WIDTH-1:0] DATA2,
    output logic [OPW-1:0]   SELECT,
    output logic             OUT_VALID
);

    logic [WIDTH-1:0] w_rd1;
    logic [WIDTH-1:0] w_rd2;
    logic [WIDTH-1:0] w_src2;
    logic [WIDTH-1:0] w_op2;

    logic [WIDTH-1:0] r_data1_q,  w_data1_d;
    logic [WIDTH-1:0] r_data2_q,  w_data2_d;
    logic [OPW-1:0]   r_select_q, w_select_d;
    logic             r_valid_q,  w_valid_d;
    logic [AW-1:0]    r_src1_q,   w_src1_d;
    logic [AW-1:0]    r_src2_q,   w_src2_d;
    logic             r_imm_q,    w_imm_d;
    logic             r_neg_q,    w_neg_d;

    reg_file u_reg_file (
        .CLK       (CLK),
        .RESET     (RESET),
        .WRITE     (WRITE),
        .INADDRESS (INADDRESS),
        .IN        (IN),
        .RADDR1    (OUT1ADDRESS),
        .RADDR2    (OUT2ADDRESS),
        .RDATA1    (w_rd1),
        .RDATA2    (w_rd2)
    );

    always_comb begin
        w_src2 = IMM_SEL ? IMMEDIATE : w_rd2;
        w_op2  = NEG_SEL ? twos_neg(w_src2) : w_src2;
    end

    always_comb begin
        w_data1_d  = r_data1_q;
        w_data2_d  = r_data2_q;
        w_select_d = r_select_q;
        w_valid_d  = r_valid_q;
        w_src1_d   = r_src1_q;
        w_src2_d   = r_src2_q;
        w_imm_d    = r_imm_q;
        w_neg_d    = r_neg_q;
        if (!STALL) begin
            w_data1_d  = w_rd1;
            w_data2_d  = w_op2;
            w_select_d = ALUOP_IN;
            w_valid_d  = IN_VALID;
            w_src1_d   = OUT1ADDRESS;
            w_src2_d   = OUT2ADDRESS;
            w_imm_d    = IMM_SEL;
            w_neg_d    = NEG_SEL;
        end else if (r_valid_q && WRITE) begin
            // Held operands track write-backs to their source registers.
            if (r_src1_q == INADDRESS) begin
                w_data1_d = IN;
            end
            if (!r_imm_q && (r_src2_q == INADDRESS)) begin
                w_data2_d = r_neg_q ? twos_neg(IN) : IN;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_data1_q  <= '0;
            r_data2_q  <= '0;
            r_select_q <= '0;
            r_valid_q  <= 1'b0;
            r_src1_q   <= '0;
            r_src2_q   <= '0;
            r_imm_q    <= 1'b0;
            r_neg_q    <= 1'b0;
        end else begin
            r_data1_q  <= w_data1_d;
            r_data2_q  <= w_data2_d;
            r_select_q <= w_select_d;
            r_valid_q  <= w_valid_d;
            r_src1_q   <= w_src1_d;
            r_src2_q   <= w_src2_d;
            r_imm_q    <= w_imm_d;
            r_neg_q    <= w_neg_d;
        end
    end

    assign DATA1     = r_data1_q;
    assign DATA2     = r_data2_q;
    assign SELECT    = r_select_q;
    assign OUT_VALID = r_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_operand_fetch_stage
// Description : Directed and randomized self-checking bench for operand fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_fetch_stage;
    import cpu_pkg::*;

    logic             CLK = 1'b0;
    logic             RESET;
    logic             IN_VALID;
    logic [AW-1:0]    OUT1ADDRESS;
    logic [AW-1:0]    OUT2ADDRESS;
    logic [WIDTH-1:0] IMMEDIATE;
    logic             IMM_SEL;
    logic             NEG_SEL;
    logic [OPW-1:0]   ALUOP_IN;
    logic             STALL;
    logic             WRITE;
    logic [AW-1:0]    INADDRESS;
    logic [WIDTH-1:0] IN;
    logic [WIDTH-1:0] DATA1;
    logic [WIDTH-1:0] DATA2;
    logic [OPW-1:0]   SELECT;
    logic             OUT_VALID;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state kept as plain integers.
    int m_reg [8];
    int m_d1, m_d2, m_sel, m_v, m_s1, m_s2, m_imm, m_neg;

    operand_fetch_stage dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .IN_VALID    (IN_VALID),
        .OUT1ADDRESS (OUT1ADDRESS),
        .OUT2ADDRESS (OUT2ADDRESS),
        .IMMEDIATE   (IMMEDIATE),
        .IMM_SEL     (IMM_SEL),
        .NEG_SEL     (NEG_SEL),
        .ALUOP_IN    (ALUOP_IN),
        .STALL       (STALL),
        .WRITE       (WRITE),
        .INADDRESS   (INADDRESS),
        .IN          (IN),
        .DATA1       (DATA1),
        .DATA2       (DATA2),
        .SELECT      (SELECT),
        .OUT_VALID   (OUT_VALID)
    );

    always #5 CLK = ~CLK;

    function automatic int neg8(input int x);
        return (256 - x) % 256;
    endfunction

    task automatic idle_inputs();
        RESET = 1'b1; IN_VALID = 1'b0; OUT1ADDRESS = '0; OUT2ADDRESS = '0;
        IMMEDIATE = '0; IMM_SEL = 1'b0; NEG_SEL = 1'b0; ALUOP_IN = '0;
        STALL = 1'b0; WRITE = 1'b0; INADDRESS = '0; IN = '0;
    endtask

    // Advance one edge, updating the reference from the presented inputs.
    task automatic cycle();
        int rd1, rd2, src2, op2;
        if (!RESET) begin
            foreach (m_reg[i]) m_reg[i] = 0;
            m_d1 = 0; m_d2 = 0; m_sel = 0; m_v = 0;
            m_s1 = 0; m_s2 = 0; m_imm = 0; m_neg = 0;
        end else begin
            rd1  = (WRITE && INADDRESS == OUT1ADDRESS) ? int'(IN) : m_reg[OUT1ADDRESS];
            rd2  = (WRITE && INADDRESS == OUT2ADDRESS) ? int'(IN) : m_reg[OUT2ADDRESS];
            src2 = IMM_SEL ? int'(IMMEDIATE) : rd2;
            op2  = NEG_SEL ? neg8(src2) : src2;
            if (!STALL) begin
                m_d1 = rd1; m_d2 = op2; m_sel = int'(ALUOP_IN); m_v = int'(IN_VALID);
                m_s1 = int'(OUT1ADDRESS); m_s2 = int'(OUT2ADDRESS);
                m_imm = int'(IMM_SEL); m_neg = int'(NEG_SEL);
            end else if (m_v == 1 && WRITE) begin
                if (m_s1 == int'(INADDRESS)) m_d1 = int'(IN);
                if (m_imm == 0 && m_s2 == int'(INADDRESS))
                    m_d2 = (m_neg == 1) ? neg8(int'(IN)) : int'(IN);
            end
            if (WRITE) m_reg[INADDRESS] = int'(IN);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        RESET = 1'b0;
        cycle();
        cycle();
        RESET = 1'b1;
        n_checks++; if (DATA1 !== 8'h00) $display("FAIL reset_data1 got %h want 00", DATA1); else n_pass++;
        n_checks++; if (DATA2 !== 8'h00) $display("FAIL reset_data2 got %h want 00", DATA2); else n_pass++;
        n_checks++; if (SELECT !== 3'b000) $display("FAIL reset_select got %b want 000", SELECT); else n_pass++;
        n_checks++; if (OUT_VALID !== 1'b0) $display("FAIL reset_valid got %b want 0", OUT_VALID); else n_pass++;
    endtask

    task automatic test_write_read();
        idle_inputs();
        WRITE = 1'b1; INADDRESS = 3'd3; IN = 8'h2A;
        cycle();
        idle_inputs();
        OUT1ADDRESS = 3'd3; ALUOP_IN = OP_ADD; IN_VALID = 1'b1;
        cycle();
        n_checks++; if (DATA1 !== 8'h2A) $display("FAIL wr_rd_data1 got %h want 2a", DATA1); else n_pass++;
        n_checks++; if (SELECT !== 3'b001) $display("FAIL wr_rd_select got %b want 001", SELECT); else n_pass++;
        n_checks++; if (OUT_VALID !== 1'b1) $display("FAIL wr_rd_valid got %b want 1", OUT_VALID); else n_pass++;
    endtask

    task automatic test_bypass();
        idle_inputs();
        WRITE = 1'b1; INADDRESS = 3'd5; IN = 8'h11;
        OUT2ADDRESS = 3'd5; IN_VALID = 1'b1;
        cycle();
        n_checks++; if (DATA2 !== 8'h11) $display("FAIL bypass_data2 got %h want 11", DATA2); else n_pass++;
    endtask

    task automatic test_imm_neg();
        logic [7:0] imm_tab [3] = '{8'h05, 8'h80, 8'h00};
        logic [7:0] exp_tab [3] = '{8'hFB, 8'h80, 8'h00};
        for (int i = 0; i < 3; i++) begin
            idle_inputs();
            IMM_SEL = 1'b1; NEG_SEL = 1'b1; IMMEDIATE = imm_tab[i]; IN_VALID = 1'b1;
            cycle();
            n_checks++;
            if (DATA2 !== exp_tab[i]) $display("FAIL imm_neg_%0d got %h want %h", i, DATA2, exp_tab[i]);
            else n_pass++;
        end
    endtask

    task automatic test_stall_refresh();
        idle_inputs();
        WRITE = 1'b1; INADDRESS = 3'd2; IN = 8'h07;
        cycle();
        idle_inputs();
        OUT1ADDRESS = 3'd2; OUT2ADDRESS = 3'd2; NEG_SEL = 1'b1;
        ALUOP_IN = OP_ADD; IN_VALID = 1'b1;
        cycle();
        n_checks++; if (DATA1 !== 8'h07) $display("FAIL stall_cap_data1 got %h want 07", DATA1); else n_pass++;
        n_checks++; if (DATA2 !== 8'hF9) $display("FAIL stall_cap_data2 got %h want f9", DATA2); else n_pass++;
        // New instruction presented under stall must not be captured.
        idle_inputs();
        STALL = 1'b1; WRITE = 1'b1; INADDRESS = 3'd2; IN = 8'h03;
        OUT1ADDRESS = 3'd6; OUT2ADDRESS = 3'd7; ALUOP_IN = OP_SL; IN_VALID = 1'b0;
        cycle();
        n_checks++; if (DATA1 !== 8'h03) $display("FAIL stall_ref_data1 got %h want 03", DATA1); else n_pass++;
        n_checks++; if (DATA2 !== 8'hFD) $display("FAIL stall_ref_data2 got %h want fd", DATA2); else n_pass++;
        n_checks++; if (SELECT !== 3'b001) $display("FAIL stall_ref_select got %b want 001", SELECT); else n_pass++;
        n_checks++; if (OUT_VALID !== 1'b1) $display("FAIL stall_ref_valid got %b want 1", OUT_VALID); else n_pass++;
        INADDRESS = 3'd4; IN = 8'h55;
        cycle();
        n_checks++; if (DATA1 !== 8'h03) $display("FAIL stall_other_data1 got %h want 03", DATA1); else n_pass++;
        n_checks++; if (DATA2 !== 8'hFD) $display("FAIL stall_other_data2 got %h want fd", DATA2); else n_pass++;
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        WRITE = 1'b1; INADDRESS = 3'd1; IN = 8'h10;
        cycle();
        idle_inputs();
        OUT1ADDRESS = 3'd1; OUT2ADDRESS = 3'd1; ALUOP_IN = OP_OR; IN_VALID = 1'b1;
        cycle();
        RESET = 1'b0; STALL = 1'b1; WRITE = 1'b1; INADDRESS = 3'd1; IN = 8'hFF;
        cycle();
        n_checks++; if (DATA1 !== 8'h00) $display("FAIL rst_mid_data1 got %h want 00", DATA1); else n_pass++;
        n_checks++; if (DATA2 !== 8'h00) $display("FAIL rst_mid_data2 got %h want 00", DATA2); else n_pass++;
        n_checks++; if (SELECT !== 3'b000) $display("FAIL rst_mid_select got %b want 000", SELECT); else n_pass++;
        n_checks++; if (OUT_VALID !== 1'b0) $display("FAIL rst_mid_valid got %b want 0", OUT_VALID); else n_pass++;
        idle_inputs();
        OUT1ADDRESS = 3'd1; IN_VALID = 1'b1;
        cycle();
        n_checks++; if (DATA1 !== 8'h00) $display("FAIL rst_mid_r1 got %h want 00", DATA1); else n_pass++;
        n_checks++; if (OUT_VALID !== 1'b1) $display("FAIL rst_mid_r1_valid got %b want 1", OUT_VALID); else n_pass++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            RESET       = ($urandom_range(0, 59) != 0);
            IN_VALID    = 1'($urandom_range(0, 1));
            OUT1ADDRESS = AW'($urandom_range(0, NREGS - 1));
            OUT2ADDRESS = AW'($urandom_range(0, NREGS - 1));
            IMMEDIATE   = 8'($urandom_range(0, 255));
            IMM_SEL     = 1'($urandom_range(0, 1));
            NEG_SEL     = 1'($urandom_range(0, 1));
            ALUOP_IN    = 3'($urandom_range(0, 7));
            STALL       = ($urandom_range(0, 2) == 0);
            WRITE       = 1'($urandom_range(0, 1));
            INADDRESS   = AW'($urandom_range(0, NREGS - 1));
            IN          = 8'($urandom_range(0, 255));
            cycle();
            n_checks++;
            if (DATA1 !== 8'(m_d1) || DATA2 !== 8'(m_d2) ||
                SELECT !== 3'(m_sel) || OUT_VALID !== 1'(m_v)) begin
                $display("FAIL random_%0d got d1=%h d2=%h sel=%b v=%b want d1=%h d2=%h sel=%b v=%b",
                         n, DATA1, DATA2, SELECT, OUT_VALID,
                         8'(m_d1), 8'(m_d2), 3'(m_sel), 1'(m_v));
            end else begin
                n_pass++;
            end
        end
        idle_inputs();
    endtask

    initial begin
        foreach (m_reg[i]) m_reg[i] = 0;
        m_d1 = 0; m_d2 = 0; m_sel = 0; m_v = 0;
        m_s1 = 0; m_s2 = 0; m_imm = 0; m_neg = 0;
        idle_inputs();
        #2;
        test_reset();
        test_write_read();
        test_bypass();
        test_imm_neg();
        test_stall_refresh();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
